cu_mc: RTL

Multi-cycle, parametrised control unit for the risc-iv core. It replaces the single-cycle registered opcode decoder. It accepts one instruction opcode per valid/ready handshake and sequences it through FETCH/DECODE/EXEC/MEM/WB states. Along the way it drives datapath enables, stalls on memory, flags illegal opcodes and counts retired instructions. It sits between the instruction register/fetch stage and the register file, ALU and data memory.

---
 rtl/cu_mc.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/cu_mc.sv
// Multi-cycle control unit for the risc-iv core: FETCH/DECODE/EXEC/MEM/WB sequencing.
// Optional BEQ/JMP support is enabled by defining CU_BRANCH_EN.
module cu_mc #(
  parameter int unsigned OPC_W    = 4,
  parameter int unsigned ALU_OP_W = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [OPC_W-1:0]    opcode,
  input  logic                mem_ready,
  input  logic                zero,
  output logic                pc_write,
  output logic                pc_src,
  output logic                reg_write,
  output logic                alu_src,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic [ALU_OP_W-1:0] alu_opn,
  output logic                busy,
  output logic                illegal,
  output logic [CNT_W-1:0]    retire_cnt
);

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb} state_e;

  state_e             state_q, state_d;
  logic [OPC_W-1:0]   ir_op_q;
  logic [CNT_W-1:0]   retire_cnt_q;
  logic [3:0]         op_lo;
  logic               hi_zero;
  logic               is_alu, is_load, is_store, is_beq, is_jmp, is_illegal;
  logic               retire;

  assign op_lo    = ir_op_q[3:0];
  assign hi_zero  = ((ir_op_q >> 4) == '0);
  assign is_alu   = hi_zero && (op_lo <= 4'd6);
  assign is_load  = hi_zero && (op_lo == 4'd7);
  assign is_store = hi_zero && (op_lo == 4'd8);
`ifdef CU_BRANCH_EN
  assign is_beq   = hi_zero && (op_lo == 4'd9);
  assign is_jmp   = hi_zero && (op_lo == 4'd10);
`else
  logic unused_zero;
  assign is_beq      = 1'b0;
  assign is_jmp      = 1'b0;
  assign unused_zero = zero;
`endif
  assign is_illegal = !(is_alu || is_load || is_store || is_beq || is_jmp);

  // Retire fires in the state whose exit edge completes the instruction.
  assign retire = (state_q == StWb) ||
                  (state_q == StMem && is_store && mem_ready) ||
                  (state_q == StExec && is_beq) ||
                  (state_q == StDecode && is_jmp);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StFetch;
      ir_op_q      <= '0;
      retire_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StFetch && instr_valid) ir_op_q <= opcode;
      if (retire) retire_cnt_q <= retire_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:  if (instr_valid) state_d = StDecode;
      StDecode: begin
        if (is_alu || is_beq)        state_d = StExec;
        else if (is_load || is_store) state_d = StMem;
        else                          state_d = StFetch;
      end
      StExec:   state_d = is_beq ? StFetch : StWb;
      StMem:    if (mem_ready) state_d = is_load ? StWb : StFetch;
      StWb:     state_d = StFetch;
      default:  state_d = StFetch;
    endcase
  end

  always_comb begin
    instr_ready = 1'b0;
    busy        = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    reg_write   = 1'b0;
    alu_src     = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_to_reg  = 1'b0;
    illegal     = 1'b0;
    alu_opn     = '0;
    if (!rst) begin
      case (state_q)
        StFetch: instr_ready = 1'b1;
        StDecode: begin
          busy = 1'b1;
          if (is_illegal) begin
            illegal = 1'b1;
          end else begin
            pc_write = 1'b1;
            alu_src  = is_load || is_store;
            pc_src   = is_jmp;
          end
        end
        StExec: begin
          busy = 1'b1;
`ifdef CU_BRANCH_EN
          if (is_beq) begin
            alu_opn[0] = 1'b1;
            pc_write   = zero;
            pc_src     = zero;
          end else begin
            alu_opn[2:0] = ir_op_q[2:0];
          end
`else
          alu_opn[2:0] = ir_op_q[2:0];
`endif
        end
        StMem: begin
          busy      = 1'b1;
          alu_src   = 1'b1;
          mem_read  = is_load;
          mem_write = is_store;
        end
        StWb: begin
          busy       = 1'b1;
          reg_write  = 1'b1;
          mem_to_reg = is_load;
          if (is_alu) alu_opn[2:0] = ir_op_q[2:0];
        end
        default: ;
      endcase
    end
  end

  assign retire_cnt = rst ? '0 : retire_cnt_q;

endmodule
